// File: rtl/snake_pkg.sv
// Shared key codes and PS/2 scan constants for the snake input path.
// The frame FSM state type and the make-code decoder live here as well.
package snake_pkg;

    localparam logic [2:0] KEY_NONE  = 3'd0;
    localparam logic [2:0] KEY_UP    = 3'd1;
    localparam logic [2:0] KEY_DOWN  = 3'd2;
    localparam logic [2:0] KEY_LEFT  = 3'd3;
    localparam logic [2:0] KEY_RIGHT = 3'd4;
    localparam logic [2:0] KEY_PAUSE = 3'd5;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;

    typedef enum logic [1:0] {
        FRAME_IDLE,
        FRAME_DATA,
        FRAME_PARITY,
        FRAME_STOP
    } frame_state_t;

    // Arrow keys only exist behind the E0 prefix; space only without it.
    function automatic logic [2:0] decode_make(input logic [7:0] code, input logic ext);
        logic [2:0] key;
        key = KEY_NONE;
        if (ext) begin
            case (code)
                SC_UP:    key = KEY_UP;
                SC_DOWN:  key = KEY_DOWN;
                SC_LEFT:  key = KEY_LEFT;
                SC_RIGHT: key = KEY_RIGHT;
                default:  key = KEY_NONE;
            endcase
        end else if (code == SC_SPACE) begin
            key = KEY_PAUSE;
        end
        return key;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronisers, stability filters,
// 11-bit frame FSM with odd-parity check and a mid-frame timeout.
module ps2_frame_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk_25M,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);
    import snake_pkg::*;

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_filt;
    logic          data_filt;
    logic [FW-1:0] clk_cnt;
    logic [FW-1:0] data_cnt;
    logic          strike;

    frame_state_t  state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity_ok;
    logic [TW-1:0] timer;

    always_ff @(posedge clk_25M or negedge rst) begin
        if (!rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // A new level is taken only after FILTER_LEN consecutive disagreeing samples;
    // the strike fires in the same cycle the filtered clock drops.
    always_ff @(posedge clk_25M or negedge rst) begin
        if (!rst) begin
            clk_filt  <= 1'b1;
            data_filt <= 1'b1;
            clk_cnt   <= '0;
            data_cnt  <= '0;
            strike    <= 1'b0;
        end else begin
            strike <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                clk_cnt <= '0;
            end else if (clk_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                clk_cnt  <= '0;
                strike   <= clk_filt;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end

            if (data_sync[1] == data_filt) begin
                data_cnt <= '0;
            end else if (data_cnt == FW'(FILTER_LEN - 1)) begin
                data_filt <= data_sync[1];
                data_cnt  <= '0;
            end else begin
                data_cnt <= data_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_25M or negedge rst) begin
        if (!rst) begin
            state      <= FRAME_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_ok  <= 1'b0;
            timer      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (strike) begin
                timer <= '0;
                case (state)
                    FRAME_IDLE: begin
                        if (!data_filt) begin
                            state   <= FRAME_DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    FRAME_DATA: begin
                        shift   <= {data_filt, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= FRAME_PARITY;
                        end
                    end
                    FRAME_PARITY: begin
                        parity_ok <= ^{shift, data_filt};
                        state     <= FRAME_STOP;
                    end
                    FRAME_STOP: begin
                        if (data_filt && parity_ok) begin
                            rx_byte    <= shift;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= FRAME_IDLE;
                    end
                    default: state <= FRAME_IDLE;
                endcase
            end else if (state != FRAME_IDLE) begin
                if (timer == TW'(TIMEOUT - 1)) begin
                    frame_err <= 1'b1;
                    state     <= FRAME_IDLE;
                    timer     <= '0;
                end else begin
                    timer <= timer + 1'b1;
                end
            end else begin
                timer <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: turns make/break/extended scan-code sequences
// into one-cycle key strobes for the snake game controller.
module ps2_key_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk_25M,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [2:0] key_stroke,
    output logic       key_valid,
    output logic       frame_err
);
    import snake_pkg::*;

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       rx_err;
    logic       ext;
    logic       brk;
    logic [2:0] make_key;

    ps2_frame_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_frame (
        .clk_25M    (clk_25M),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (rx_err)
    );

    assign make_key  = decode_make(rx_byte, ext);
    assign frame_err = rx_err;

    // A corrupted frame drops any pending prefix so it cannot pair with a later byte.
    always_ff @(posedge clk_25M or negedge rst) begin
        if (!rst) begin
            ext        <= 1'b0;
            brk        <= 1'b0;
            key_stroke <= KEY_NONE;
            key_valid  <= 1'b0;
        end else begin
            key_stroke <= KEY_NONE;
            key_valid  <= 1'b0;
            if (rx_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_valid) begin
                case (rx_byte)
                    SC_EXT: ext <= 1'b1;
                    SC_BRK: brk <= 1'b1;
                    default: begin
                        if (!brk && make_key != KEY_NONE) begin
                            key_stroke <= make_key;
                            key_valid  <= 1'b1;
                        end
                        ext <= 1'b0;
                        brk <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed plus randomised PS/2 frames into ps2_key_rx; a queue of expected
// key codes is matched against every key_valid strobe.
module tb_ps2_key_rx;
    import snake_pkg::*;

    logic       clk_25M = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [2:0] key_stroke;
    logic       key_valid;
    logic       frame_err;

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    int strobe_cnt = 0;
    int exp_strobes = 0;
    bit mon_en = 1'b0;
    logic [2:0] sb_q[$];

    ps2_key_rx dut (
        .clk_25M    (clk_25M),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_stroke (key_stroke),
        .key_valid  (key_valid),
        .frame_err  (frame_err)
    );

    always #20 clk_25M = ~clk_25M;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_25M);
    endtask

    // Sends the first n_bits of an 11-bit frame (start, 8 data LSB first, odd parity, stop).
    task automatic applyStimulus(input logic [7:0] code, input bit bad_parity, input int half, input int n_bits);
        logic [10:0] frame;
        frame = {1'b1, (~^code) ^ bad_parity, code, 1'b0};
        for (int i = 0; i < n_bits; i++) begin
            ps2_data = frame[i];
            waitCycles(half);
            ps2_clk = 1'b0;
            waitCycles(half);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic sendByte(input logic [7:0] code, input int half = 15, input int gap = 40);
        applyStimulus(code, 1'b0, half, 11);
        ps2_data = 1'b1;
        waitCycles(gap);
    endtask

    function automatic logic [7:0] scan_of(input logic [2:0] key);
        case (key)
            KEY_UP:    return 8'h75;
            KEY_DOWN:  return 8'h72;
            KEY_LEFT:  return 8'h6B;
            KEY_RIGHT: return 8'h74;
            default:   return 8'h29;
        endcase
    endfunction

    task automatic expectKey(input logic [2:0] key);
        sb_q.push_back(key);
        exp_strobes++;
    endtask

    always @(negedge clk_25M) begin
        if (frame_err) err_cnt++;
        if (mon_en) begin
            if (key_valid) begin
                strobe_cnt++;
                total++;
                assert (sb_q.size() > 0) else begin
                    bad++;
                    $error("[TB] FAIL unexpected_strobe observed key=%0d expected no strobe", key_stroke);
                end
                if (sb_q.size() > 0) checkOutput("strobe_key", 32'(key_stroke), 32'(sb_q.pop_front()));
            end else begin
                checkOutput("idle_key_zero", 32'(key_stroke), 32'(KEY_NONE));
            end
        end
    end

    initial begin
        repeat (98000) @(posedge clk_25M);
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e0;
        int s0;
        logic [2:0] k;
        int half;
        int gap;

        waitCycles(3);
        checkOutput("reset_key_stroke", 32'(key_stroke), 0);
        checkOutput("reset_key_valid", 32'(key_valid), 0);
        checkOutput("reset_frame_err", 32'(frame_err), 0);
        rst = 1'b1;
        mon_en = 1'b1;
        waitCycles(20);

        e0 = err_cnt; s0 = strobe_cnt;
        sendByte(SC_EXT);
        expectKey(KEY_UP);
        sendByte(SC_UP);
        checkOutput("up_strobes", strobe_cnt - s0, 1);
        checkOutput("up_no_err", err_cnt - e0, 0);

        s0 = strobe_cnt;
        sendByte(SC_EXT);
        sendByte(SC_BRK);
        sendByte(SC_UP);
        checkOutput("break_up_strobes", strobe_cnt - s0, 0);
        expectKey(KEY_PAUSE);
        sendByte(SC_SPACE);
        checkOutput("pause_strobes", strobe_cnt - s0, 1);
        s0 = strobe_cnt;
        sendByte(SC_UP);
        checkOutput("lone_75_strobes", strobe_cnt - s0, 0);

        e0 = err_cnt; s0 = strobe_cnt;
        applyStimulus(SC_LEFT, 1'b1, 15, 11);
        waitCycles(40);
        checkOutput("parity_err_count", err_cnt - e0, 1);
        checkOutput("parity_err_strobes", strobe_cnt - s0, 0);
        sendByte(SC_EXT);
        expectKey(KEY_LEFT);
        sendByte(SC_LEFT);
        checkOutput("left_strobes", strobe_cnt - s0, 1);

        e0 = err_cnt; s0 = strobe_cnt;
        applyStimulus(SC_RIGHT, 1'b0, 15, 5);
        ps2_data = 1'b1;
        waitCycles(49900);
        checkOutput("timeout_not_early", err_cnt - e0, 0);
        waitCycles(300);
        checkOutput("timeout_err_count", err_cnt - e0, 1);
        sendByte(SC_EXT);
        expectKey(KEY_RIGHT);
        sendByte(SC_RIGHT);
        checkOutput("right_strobes", strobe_cnt - s0, 1);
        checkOutput("right_no_err", err_cnt - e0, 1);

        e0 = err_cnt; s0 = strobe_cnt;
        ps2_clk = 1'b0;
        waitCycles(5);
        ps2_clk = 1'b1;
        waitCycles(40);
        checkOutput("glitch_no_err", err_cnt - e0, 0);
        expectKey(KEY_PAUSE);
        sendByte(SC_SPACE);
        checkOutput("glitch_then_pause", strobe_cnt - s0, 1);

        e0 = err_cnt; s0 = strobe_cnt;
        applyStimulus(SC_EXT, 1'b0, 15, 4);
        waitCycles(3);
        rst = 1'b0;
        #1;
        checkOutput("midreset_key_stroke", 32'(key_stroke), 0);
        checkOutput("midreset_key_valid", 32'(key_valid), 0);
        checkOutput("midreset_frame_err", 32'(frame_err), 0);
        ps2_data = 1'b1;
        waitCycles(5);
        rst = 1'b1;
        waitCycles(20);
        sendByte(SC_EXT);
        expectKey(KEY_DOWN);
        sendByte(SC_DOWN);
        checkOutput("down_strobes", strobe_cnt - s0, 1);
        checkOutput("down_no_err", err_cnt - e0, 0);

        for (int it = 0; it < 8; it++) begin
            k = 3'($urandom_range(1, 5));
            half = $urandom_range(15, 25);
            gap = $urandom_range(20, 100);
            if ($urandom_range(0, 2) == 0) begin
                if (k != KEY_PAUSE) sendByte(SC_EXT, half, gap);
                sendByte(SC_BRK, half, gap);
                sendByte(scan_of(k), half, gap);
            end
            if (k != KEY_PAUSE) sendByte(SC_EXT, half, gap);
            expectKey(k);
            sendByte(scan_of(k), half, gap);
        end

        waitCycles(100);
        checkOutput("sb_drained", sb_q.size(), 0);
        checkOutput("total_strobes", strobe_cnt, exp_strobes);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
